// File: rtl/tristate_bus_pkg.sv
// Shared types and default sizing for the tristate bus arbiter.
// Imported by the interface, the priority picker and the top-level FSM.
package tristate_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  localparam int DEF_N          = 4;
  localparam int DEF_TURNAROUND = 1;
  localparam int DEF_MAX_HOLD   = 8;
  localparam int TURN_CNT_W     = 3;

endpackage

// File: rtl/tristate_bus_arbiter_if.sv
// Request/enable bundle between the requesters and the arbiter.
// The arbiter takes the master view; the requester side takes the slave view.
interface tristate_bus_arbiter_if
  import tristate_bus_pkg::*;
#(
  parameter int N = DEF_N
);
  localparam int OW = $clog2(N);

  logic [N-1:0]  req;
  logic [N-1:0]  oe;
  logic [OW-1:0] owner;
  logic          bus_busy;
  logic          turn;

  modport master (
    input  req,
    output oe,
    output owner,
    output bus_busy,
    output turn
  );

  modport slave (
    output req,
    input  oe,
    input  owner,
    input  bus_busy,
    input  turn
  );
endinterface

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Wrap-around priority search: first set request at or above the pointer.
// Purely combinational; shared by the IDLE and TURN grant decisions.
module rr_pick
  import tristate_bus_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] pointer,
  output logic                 found,
  output logic [$clog2(N)-1:0] index
);
  localparam int W  = $clog2(N);
  localparam int W1 = W + 1;

  logic [W-1:0] rot_idx [N];

  // rot_idx[k] is the requester examined at priority rank k
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    logic [W1-1:0] sum;
    assign sum         = {1'b0, pointer} + W1'(gi);
    assign rot_idx[gi] = (sum >= W1'(N)) ? W'(sum - W1'(N)) : W'(sum);
  end

  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[rot_idx[k]]) begin
        found = 1'b1;
        index = rot_idx[k];
      end
    end
  end
endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of N tristate output enables with a dead interval
// between owners and a hold limit that only bites when someone else waits.
module tristate_bus_arbiter
  import tristate_bus_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int TURNAROUND = DEF_TURNAROUND,
  parameter int MAX_HOLD   = DEF_MAX_HOLD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tristate_bus_arbiter_if.master bus
);
  localparam int W  = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);

  localparam logic [HW-1:0]         HOLD_LAST  = HW'(MAX_HOLD);
  localparam logic [TURN_CNT_W-1:0] TURN_LAST  = TURN_CNT_W'(TURNAROUND);
  localparam logic [W-1:0]          OWNER_LAST = W'(N - 1);
  localparam logic [N-1:0]          ONE_HOT0   = N'(1);

  state_t                  state_reg;
  logic [N-1:0]            oe_reg;
  logic [W-1:0]            owner_reg;
  logic [W-1:0]            rr_ptr_reg;
  logic [HW-1:0]           hold_reg;
  logic [TURN_CNT_W-1:0]   turn_cnt_reg;
  logic                    bus_busy_reg;
  logic                    turn_reg;

  logic                    pick_found;
  logic [W-1:0]            pick_index;
  logic [N-1:0]            pick_oe;
  logic                    owner_req;
  logic                    others_pending;
  logic                    release_bus;
  logic [W-1:0]            ptr_after_owner;

  rr_pick #(.N(N)) u_pick (
    .req     (bus.req),
    .pointer (rr_ptr_reg),
    .found   (pick_found),
    .index   (pick_index)
  );

  assign pick_oe         = ONE_HOT0 << pick_index;
  assign owner_req       = bus.req[owner_reg];
  // oe_reg is the owner's one-hot while in OWN, so masking it leaves the waiters
  assign others_pending  = |(bus.req & ~oe_reg);
  assign release_bus     = !owner_req || ((hold_reg == HOLD_LAST) && others_pending);
  assign ptr_after_owner = (owner_reg == OWNER_LAST) ? '0 : owner_reg + W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      oe_reg       <= '0;
      owner_reg    <= '0;
      rr_ptr_reg   <= '0;
      hold_reg     <= '0;
      turn_cnt_reg <= '0;
      bus_busy_reg <= 1'b0;
      turn_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            state_reg    <= OWN;
            oe_reg       <= pick_oe;
            owner_reg    <= pick_index;
            bus_busy_reg <= 1'b1;
            hold_reg     <= HW'(1);
          end
        end

        OWN: begin
          if (release_bus) begin
            // Release beats any simultaneous new request: always pass through TURN
            state_reg    <= TURN;
            oe_reg       <= '0;
            bus_busy_reg <= 1'b0;
            turn_reg     <= 1'b1;
            turn_cnt_reg <= TURN_CNT_W'(1);
            rr_ptr_reg   <= ptr_after_owner;
            hold_reg     <= '0;
          end else if (hold_reg != HOLD_LAST) begin
            hold_reg <= hold_reg + HW'(1);
          end
        end

        TURN: begin
          if (turn_cnt_reg == TURN_LAST) begin
            turn_reg     <= 1'b0;
            turn_cnt_reg <= '0;
            if (pick_found) begin
              state_reg    <= OWN;
              oe_reg       <= pick_oe;
              owner_reg    <= pick_index;
              bus_busy_reg <= 1'b1;
              hold_reg     <= HW'(1);
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            turn_cnt_reg <= turn_cnt_reg + TURN_CNT_W'(1);
          end
        end

        default: begin
          state_reg    <= IDLE;
          oe_reg       <= '0;
          bus_busy_reg <= 1'b0;
          turn_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oe       = oe_reg;
  assign bus.owner    = owner_reg;
  assign bus.bus_busy = bus_busy_reg;
  assign bus.turn     = turn_reg;
endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Two arbiters (turnaround 1 and 3) share one request vector; each has its own
// reference model feeding an event queue that a negedge monitor drains.
module tb_tristate_bus_arbiter;
  localparam int NR = 4;
  localparam int MH = 8;

  typedef struct {
    int         cyc;
    logic [9:0] t;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   req;

  logic [1:0][3:0] oe_w;
  logic [1:0][1:0] own_w;
  logic [1:0]      busy_w;
  logic [1:0]      turn_w;

  int compared   = 0;
  int mismatched = 0;
  int pushed [2] = '{0, 0};
  int popped [2] = '{0, 0};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    int res;
    res = -1;
    for (int k = NR - 1; k >= 0; k--) begin
      if (r[(p + k) % NR]) res = (p + k) % NR;
    end
    return res;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int TA = (gi == 0) ? 1 : 3;

    tristate_bus_arbiter_if #(.N(NR)) bus ();
    assign bus.req = req;

    tristate_bus_arbiter #(.N(NR), .TURNAROUND(TA), .MAX_HOLD(MH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    assign oe_w[gi]   = bus.oe;
    assign own_w[gi]  = bus.owner;
    assign busy_w[gi] = bus.bus_busy;
    assign turn_w[gi] = bus.turn;

    exp_t exp_q[$];

    // Reference model: who owns the bus, how long, and how many dead edges remain
    int         cur  = -1;
    int         held = 0;
    int         gap  = 0;
    int         ptr  = 0;
    int         mcyc = 0;
    logic [9:0] last_t = '0;
    initial begin
      logic [9:0] t;
      int         p;
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          cur = -1; held = 0; gap = 0; ptr = 0; mcyc = 0; last_t = '0;
          pushed[gi] = pushed[gi] - exp_q.size();
          exp_q.delete();
        end else begin
          mcyc++;
          if (cur >= 0) begin
            if (!req[cur] || (held == MH && (req & ~(4'b0001 << cur)) != 0)) begin
              ptr = (cur + 1) % NR;
              cur = -1;
              gap = TA;
            end else if (held < MH) begin
              held++;
            end
          end else begin
            if (gap > 0) gap--;
            if (gap == 0) begin
              p = pick(req, ptr);
              if (p >= 0) begin
                cur  = p;
                held = 1;
              end
            end
          end
          t = {gap > 0, cur >= 0, (cur >= 0) ? 4'(cur) : 4'd0,
               (cur >= 0) ? (4'b0001 << cur) : 4'd0};
          if (t != last_t) begin
            exp_q.push_back('{cyc: mcyc, t: t});
            pushed[gi]++;
            last_t = t;
          end
        end
      end
    end

    int mon_cyc = 0;
    initial begin
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) mon_cyc = 0;
        else        mon_cyc++;
      end
    end

    logic [9:0] mlast = '0;
    initial begin
      logic [9:0] dt;
      exp_t       e;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          mlast = '0;
        end else begin
          compared++;
          if ($countones(bus.oe) > 1) begin
            mismatched++;
            $display("FAIL sb%0d_onehot: got oe=%b required at most one bit", gi, bus.oe);
          end
          compared++;
          if (bus.bus_busy != (bus.oe != 0)) begin
            mismatched++;
            $display("FAIL sb%0d_busy: got busy=%b required %b", gi, bus.bus_busy, bus.oe != 0);
          end
          dt = {bus.turn, bus.bus_busy, bus.bus_busy ? 4'(bus.owner) : 4'd0, bus.oe};
          if (dt != mlast) begin
            compared++;
            if (exp_q.size() == 0) begin
              mismatched++;
              $display("FAIL sb%0d_unexpected: got t=%b at cyc %0d required no change", gi, dt, mon_cyc);
            end else begin
              e = exp_q.pop_front();
              popped[gi]++;
              if (e.t != dt || e.cyc != mon_cyc) begin
                mismatched++;
                $display("FAIL sb%0d_event: got t=%b cyc=%0d required t=%b cyc=%0d",
                         gi, dt, mon_cyc, e.t, e.cyc);
              end
            end
            mlast = dt;
          end
        end
      end
    end
  end

  initial begin
    int        cnt;
    int        grants[$];
    logic [3:0] prev;

    req   = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_oe", oe_w[i], 0);
      chk("rst_busy", busy_w[i], 0);
      chk("rst_turn", turn_w[i], 0);
      chk("rst_owner", own_w[i], 0);
    end

    // single request, one-clock grant latency
    rst_n = 1'b1;
    req   = 4'b0100;
    @(negedge clk);
    chk("t1_oe", oe_w[0], 4);
    chk("t1_owner", own_w[0], 2);
    chk("t1_busy", busy_w[0], 1);
    chk("t1_oe_ta3", oe_w[1], 4);

    // owner releases with another request pending
    req = 4'b0001;
    @(negedge clk);
    chk("t2_dead_oe", oe_w[0], 0);
    chk("t2_dead_turn", turn_w[0], 1);
    @(negedge clk);
    chk("t2_next_oe", oe_w[0], 1);

    // everyone requesting: rotation with preemption after MAX_HOLD
    req  = 4'b1111;
    prev = oe_w[0];
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (oe_w[0] != 0 && prev == 0) grants.push_back(int'(own_w[0]));
      prev = oe_w[0];
    end
    chk("t3_grant_count", grants.size(), 4);
    if (grants.size() >= 4) begin
      chk("t3_grant0", grants[0], 1);
      chk("t3_grant1", grants[1], 2);
      chk("t3_grant2", grants[2], 3);
      chk("t3_grant3", grants[3], 0);
    end

    // lone requester is never preempted
    req = 4'b0010;
    repeat (10) @(negedge clk);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (oe_w[0] == 4'b0010) cnt++;
    end
    chk("t4_hold_cycles", cnt, 30);

    // asynchronous reset while owning
    req = 4'b1000;
    repeat (4) @(negedge clk);
    chk("t5_own_oe", oe_w[0], 8);
    chk("t5_own_oe_ta3", oe_w[1], 8);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_oe", oe_w[0], 0);
    chk("t5_async_oe_ta3", oe_w[1], 0);
    chk("t5_async_busy", busy_w[0], 0);
    req = 4'b1001;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_ptr_owner", own_w[0], 0);
    chk("t5_ptr_oe", oe_w[0], 1);
    chk("t5_ptr_owner_ta3", own_w[1], 0);

    // longer turnaround, release to idle, then fresh request
    req = 4'b0001;
    repeat (3) @(negedge clk);
    req = 4'b0000;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (turn_w[1]) cnt++;
      else if (cnt > 0) break;
    end
    chk("t6_turn_len", cnt, 3);
    chk("t6_idle_busy", busy_w[1], 0);
    chk("t6_idle_turn", turn_w[1], 0);
    req = 4'b0010;
    @(negedge clk);
    chk("t6_regrant_oe", oe_w[1], 2);
    chk("t6_regrant_oe_ta1", oe_w[0], 2);

    // random level requests, mostly held across many cycles
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int b = 0; b < NR; b++) begin
        if ($urandom_range(7) == 0) req[b] = ~req[b];
      end
      if ($urandom_range(99) == 0) req = 4'b1111;
    end

    req = '0;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("sb_drained", popped[i], pushed[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/tristate_bus_arbiter.md
Name: tristate_bus_arbiter

Overview:
Round-robin arbiter that owns the output-enable lines of N tristate drivers sharing one bus wire group. Each enable goes straight to the enable input of one tristate buffer stage downstream, so at most one driver is ever enabled. A programmable dead (turnaround) interval, with all enables low, separates consecutive owners so drivers never contend. Hold-time limiting prevents one requester from starving the others.

Parameters:
N, 4, number of requesters / tristate drivers (2..16)
TURNAROUND, 1, dead cycles with all oe low between owners (1..7)
MAX_HOLD, 8, max consecutive owned cycles while another requester waits (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  N  level request per requester; held high while it wants the bus
oe  output  N  one-hot-or-zero tristate enable per driver; registered
owner  output  $clog2(N)  index of current owner; valid only when bus_busy=1
bus_busy  output  1  high while any oe bit is high
turn  output  1  high during turnaround (all oe low)

Behaviour:
- Reset (async assert, sync release): oe=0, owner=0, bus_busy=0, turn=0, state=IDLE, rr pointer=0, hold counter=0.
- All outputs are registered. oe is one-hot or zero in every cycle, including across reset assertion.
- States: IDLE, OWN, TURN.
- IDLE: if req!=0 at an edge, pick the first set req bit searching from rr pointer upward with wrap (pointer index included). Go to OWN, set oe bit, set owner, hold=1. Latency req->oe is 1 clock.
- OWN:
  - If req[owner]=0: go to TURN. oe clears on the same edge.
  - If hold==MAX_HOLD and any other req bit is set: preempt and go to TURN.
  - If hold==MAX_HOLD and no other requester is pending: stay in OWN. hold saturates at MAX_HOLD.
  - Otherwise hold increments each cycle.
- Leaving OWN: rr pointer = owner+1 mod N.
- TURN: turn=1, oe=0. Stays exactly TURNAROUND cycles, then:
  - If req!=0, grant directly to the next owner (TURN->OWN, same pick rule). A requester is never re-granted without a turnaround first.
  - Otherwise go to IDLE.
- A preempted requester that keeps req high re-enters arbitration normally. It has the lowest priority because the pointer has passed it.
- Simultaneous release by the owner and new requests: the release wins. TURN is entered, and the new requests are serviced after it.
- A req bit dropping while not owner has no effect (no latching).
- Reset mid-OWN: oe drops immediately (async) and the rr pointer returns to 0.
- Width: hold counter is $clog2(MAX_HOLD+1) bits. Turn counter is 3 bits.

Decomposition:
- Package tristate_bus_pkg: state enum (IDLE, OWN, TURN) and default parameter constants.
- One combinational sub-module, rr_pick: inputs req[N] and pointer; outputs found and index. This is the wrap-around priority search, reused by IDLE and TURN.
- The FSM and counters stay in the top module.

Test Plan:
1. Reset then req=4'b0100 -> oe=4'b0100, owner=2, one clock after req seen; bus_busy=1.
2. Owner 2 drops req with req=4'b0001 pending, TURNAROUND=1 -> oe=0 and turn=1 for exactly 1 cycle, then oe=4'b0001.
3. req=4'b1111 held constantly, MAX_HOLD=8 -> grant order 0,1,2,3,0. Each owns 8 cycles with 1 dead cycle between owners; oe never has two bits set.
4. Only req[1] held for 40 cycles -> oe=4'b0010 continuously, no preemption; hold saturates at 8.
5. rst_n asserted low mid-OWN (oe=4'b1000) -> oe=0 asynchronously before the next edge. After release with req=4'b1001, owner=0 (pointer reset).
6. TURNAROUND=3 and release with no pending req -> turn high for 3 cycles, then IDLE with bus_busy=0. A later req=4'b0010 gives oe=4'b0010 after 1 clock.
